// File: rtl/intern_link_buffer.sv
//==============================================================================
// Module      : intern_link_buffer
// Description : Per-VC buffered link stage with on/off and allocatable
//               back-pressure, replaying flits round-robin to the next link.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package noc_params;
    localparam int VC_NUM  = 4;
    localparam int VC_SIZE = $clog2(VC_NUM);
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        logic [DATA_W-1:0]  data;
    } flit_t;
endpackage

module intern_link_buffer
    import noc_params::*;
#(
    parameter int BUFFER_SIZE    = 8,
    parameter int ON_OFF_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  flit_t             rx_port_data,
    input  logic              rx_port_is_valid,
    output logic [VC_NUM-1:0] rx_port_is_on_off,
    output logic [VC_NUM-1:0] rx_port_is_allocatable,
    output flit_t             tx_port_data,
    output logic              tx_port_is_valid,
    input  logic [VC_NUM-1:0] tx_port_is_on_off,
    input  logic [VC_NUM-1:0] tx_port_is_allocatable,
    output logic              overflow_err
);

    localparam int c_ptr_w = $clog2(BUFFER_SIZE);
    localparam int c_cnt_w = $clog2(BUFFER_SIZE + 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt  = c_cnt_w'(BUFFER_SIZE);
    localparam logic [c_cnt_w-1:0] c_on_off_th = c_cnt_w'(BUFFER_SIZE - ON_OFF_LATENCY);

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_BUSY = 1'b1
    } rx_state_e;

    flit_t              r_mem_q    [VC_NUM][BUFFER_SIZE];
    logic [c_ptr_w-1:0] r_rd_ptr_q [VC_NUM];
    logic [c_ptr_w-1:0] w_rd_ptr_d [VC_NUM];
    logic [c_ptr_w-1:0] r_wr_ptr_q [VC_NUM];
    logic [c_ptr_w-1:0] w_wr_ptr_d [VC_NUM];
    logic [c_cnt_w-1:0] r_count_q  [VC_NUM];
    logic [c_cnt_w-1:0] w_count_d  [VC_NUM];
    rx_state_e          r_rx_state_q [VC_NUM];
    rx_state_e          w_rx_state_d [VC_NUM];
    logic [VC_NUM-1:0]  r_tx_open_q, w_tx_open_d;
    logic [VC_SIZE-1:0] r_rr_ptr_q, w_rr_ptr_d;
    flit_t              r_tx_data_q, w_tx_data_d;
    logic               r_tx_valid_q, w_tx_valid_d;
    logic               r_overflow_q, w_overflow_d;

    flit_t              w_front [VC_NUM];
    logic [VC_NUM-1:0]  w_eligible;
    logic               w_grant;
    logic [VC_SIZE-1:0] w_grant_vc;
    logic [VC_SIZE-1:0] w_scan_vc;
    logic [VC_SIZE-1:0] w_wr_vc;
    logic               w_accept;
    logic               w_front_is_head;

    // Eligibility and round-robin pick starting at r_rr_ptr_q.
    always_comb begin
        w_grant    = 1'b0;
        w_grant_vc = '0;
        w_scan_vc  = '0;
        w_eligible = '0;
        w_front_is_head = 1'b0;
        for (int v = 0; v < VC_NUM; v++) begin
            w_front[v]      = r_mem_q[v][r_rd_ptr_q[v]];
            w_front_is_head = (w_front[v].flit_label == HEAD) || (w_front[v].flit_label == HEADTAIL);
            w_eligible[v]   = (r_count_q[v] != '0) && tx_port_is_on_off[v] &&
                              (!w_front_is_head || (!r_tx_open_q[v] && tx_port_is_allocatable[v]));
        end
        for (int i = 0; i < VC_NUM; i++) begin
            w_scan_vc = VC_SIZE'((int'(r_rr_ptr_q) + i) % VC_NUM);
            if (!w_grant && w_eligible[w_scan_vc]) begin
                w_grant    = 1'b1;
                w_grant_vc = w_scan_vc;
            end
        end
    end

    // A full VC still accepts when it is being drained in the same cycle.
    always_comb begin
        w_wr_vc  = rx_port_data.vc_id;
        w_accept = rx_port_is_valid &&
                   ((r_count_q[w_wr_vc] != c_full_cnt) || (w_grant && (w_grant_vc == w_wr_vc)));
    end

    always_comb begin
        w_rd_ptr_d   = r_rd_ptr_q;
        w_wr_ptr_d   = r_wr_ptr_q;
        w_count_d    = r_count_q;
        w_rx_state_d = r_rx_state_q;
        w_tx_open_d  = r_tx_open_q;
        w_rr_ptr_d   = r_rr_ptr_q;
        w_tx_valid_d = w_grant;
        w_tx_data_d  = r_tx_data_q;
        w_overflow_d = r_overflow_q | (rx_port_is_valid & ~w_accept);

        if (w_grant) begin
            w_tx_data_d             = w_front[w_grant_vc];
            w_rd_ptr_d[w_grant_vc]  = r_rd_ptr_q[w_grant_vc] + 1'b1;
            w_rr_ptr_d              = (w_grant_vc == VC_SIZE'(VC_NUM - 1)) ? '0 : w_grant_vc + 1'b1;
            case (w_front[w_grant_vc].flit_label)
                HEAD:           w_tx_open_d[w_grant_vc] = 1'b1;
                TAIL, HEADTAIL: w_tx_open_d[w_grant_vc] = 1'b0;
                default:        w_tx_open_d[w_grant_vc] = r_tx_open_q[w_grant_vc];
            endcase
        end

        if (w_accept) begin
            w_wr_ptr_d[w_wr_vc] = r_wr_ptr_q[w_wr_vc] + 1'b1;
        end

        for (int v = 0; v < VC_NUM; v++) begin
            w_count_d[v] = r_count_q[v]
                         + c_cnt_w'(w_accept && (w_wr_vc == VC_SIZE'(v)))
                         - c_cnt_w'(w_grant && (w_grant_vc == VC_SIZE'(v)));
            // The VC is released once its closing flit is presented on tx.
            if (r_tx_valid_q && (r_tx_data_q.vc_id == VC_SIZE'(v)) &&
                ((r_tx_data_q.flit_label == TAIL) || (r_tx_data_q.flit_label == HEADTAIL))) begin
                w_rx_state_d[v] = RX_IDLE;
            end
            if (w_accept && (w_wr_vc == VC_SIZE'(v)) &&
                ((rx_port_data.flit_label == HEAD) || (rx_port_data.flit_label == HEADTAIL))) begin
                w_rx_state_d[v] = RX_BUSY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr_q   <= '{default: '0};
            r_wr_ptr_q   <= '{default: '0};
            r_count_q    <= '{default: '0};
            r_rx_state_q <= '{default: RX_IDLE};
            r_tx_open_q  <= '0;
            r_rr_ptr_q   <= '0;
            r_tx_data_q  <= '0;
            r_tx_valid_q <= 1'b0;
            r_overflow_q <= 1'b0;
        end else begin
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_count_q    <= w_count_d;
            r_rx_state_q <= w_rx_state_d;
            r_tx_open_q  <= w_tx_open_d;
            r_rr_ptr_q   <= w_rr_ptr_d;
            r_tx_data_q  <= w_tx_data_d;
            r_tx_valid_q <= w_tx_valid_d;
            r_overflow_q <= w_overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_mem_q[w_wr_vc][r_wr_ptr_q[w_wr_vc]] <= rx_port_data;
        end
    end

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc_flags
        assign rx_port_is_on_off[v]      = (r_count_q[v] < c_on_off_th);
        assign rx_port_is_allocatable[v] = (r_rx_state_q[v] == RX_IDLE);
    end

    assign tx_port_data     = r_tx_data_q;
    assign tx_port_is_valid = r_tx_valid_q;
    assign overflow_err     = r_overflow_q;

endmodule

`default_nettype wire

// File: doc/intern_link_buffer.md
# intern_link_buffer

Buffered, flow-controlled link stage for the intern (cross-sub-network) path of the chiplet NoC. It terminates a router2router link as a receiver and drives a second router2router link as a transmitter. Its receive side accepts flits from an outport arbiter's intern port, stores them in per-VC FIFOs, and generates on/off and allocatable back-pressure. Its transmit side replays the flits one per cycle toward the other sub-network's inport arbiter, honouring that side's per-VC on/off and allocatable signals. VC ids pass through unchanged.

## Interface
- BUFFER_SIZE, 8: flit slots per VC FIFO; power of two, ≥4.
- ON_OFF_LATENCY, 2: slack reserved for in-flight flits; 0 < ON_OFF_LATENCY < BUFFER_SIZE.
- VC_NUM, flit_t, flit labels: taken from noc_params.

- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- rx_port  router2router.downstream  (data: flit_t, is_valid: 1, is_on_off: VC_NUM, is_allocatable: VC_NUM)  receive link.
- tx_port  router2router.upstream  (same widths)  transmit link.
- overflow_err  output  1  sticky; a flit arrived for a full VC.

## Operation
Per-VC storage and receive side:
- Each VC v has a circular FIFO with its own state:
  - rd_ptr and wr_ptr, each log2(BUFFER_SIZE) bits, wrapping naturally.
  - count[v], $clog2(BUFFER_SIZE+1) bits.
- Write: when rx_port.is_valid is high, the flit goes to FIFO[data.vc_id].
  - The flit is accepted if count < BUFFER_SIZE, or if the same VC is dequeued in the same cycle.
  - Otherwise the flit is dropped and overflow_err is set. Only rst clears overflow_err.
- rx_port.is_on_off[v] = (count[v] < BUFFER_SIZE − ON_OFF_LATENCY). It is combinational from the registered count.
- Receive VC state, per VC, two states:
  - RX_IDLE → RX_BUSY on acceptance of a HEAD or HEADTAIL flit.
  - RX_BUSY → RX_IDLE on dequeue of a TAIL or HEADTAIL flit from that VC.
  - A HEADTAIL accepted while RX_IDLE stays RX_BUSY until it is dequeued.
- rx_port.is_allocatable[v] = (state == RX_IDLE).

Transmit side:
- Transmit VC state, per VC: tx_open[v].
  - Set when a HEAD is sent.
  - Cleared when a TAIL is sent.
  - A HEADTAIL leaves it clear.
- VC v is eligible when all of the following hold:
  - count[v] > 0;
  - tx_port.is_on_off[v] = 1;
  - if the front flit is HEAD or HEADTAIL: tx_open[v] = 0 and tx_port.is_allocatable[v] = 1.
- Arbitration: round-robin over eligible VCs, starting at rr_ptr. After a grant to VC g, rr_ptr becomes (g+1) mod VC_NUM. rr_ptr is unchanged when there is no grant.
- The granted flit is dequeued and registered into tx_port.data, with tx_port.is_valid = 1 in the next cycle.
- With no grant: tx_port.is_valid = 0 and tx_port.data holds its last value.

## Timing
Reset values (rst high at a clock edge):
- All pointers and counts = 0; rr_ptr = 0.
- All RX states = RX_IDLE; all tx_open = 0.
- tx_port.is_valid = 0; tx_port.data = 0; overflow_err = 0.
- Hence rx_port.is_on_off = all-ones and rx_port.is_allocatable = all-ones from the first cycle after reset.
- rst asserted mid-packet discards all buffered flits with no partial output.

Latency:
- A flit presented on rx in cycle N is stored at the end of N.
- It is arbitrated in N+1 and appears on tx in N+2 (2-cycle minimum latency). There is no bypass path.
- Throughput: one flit per cycle in, one flit per cycle out.
- On/off timing: rx_port.is_on_off[v] reflects count at the start of the cycle. A write in cycle N lowers on/off no earlier than N+1.

Boundary conditions:
- Simultaneous write and dequeue on the same VC: count unchanged, both pointers advance. On a full VC this write is accepted.
- Empty VC: never eligible, even if a flit for it arrives in the same cycle.
- Upstream tx_port.is_on_off[v] drop: affects eligibility in the same cycle. No flit already registered is retracted.
- A flit presented while rst is high is ignored.

## Test plan
- Reset then single HEADTAIL on VC0 in cycle 1:
  - tx valid in cycle 3 with identical data;
  - rx is_allocatable[0] low in cycles 2–3, high from cycle 4.
- Fill: BUFFER_SIZE=8, ON_OFF_LATENCY=2, tx is_on_off[1]=0, push 6 flits on VC1:
  - rx is_on_off[1] falls the cycle after the 6th write;
  - 2 more writes are accepted;
  - a 9th write sets overflow_err and is dropped.
- Drain from the full state: release tx is_on_off[1]:
  - 8 flits leave in order on consecutive cycles;
  - rx is_on_off[1] rises once count < 6.
- Round robin: one 3-flit packet each on VC0 and VC1, written interleaved:
  - tx order alternates VC0, VC1 per cycle;
  - tx_open toggles correctly.
- Head blocking: tx is_allocatable[2]=0 with a HEAD at the front of VC2:
  - no VC2 output until is_allocatable rises;
  - VC3 traffic flows meanwhile.
- Mid-packet reset after HEAD+BODY on VC0:
  - all outputs return to reset values;
  - no TAIL is ever emitted.
